// File: rtl/an_arbiter_pkg.sv
// Shared encodings for the 1000BASE-X auto-negotiation arbiter.
package an_arbiter_pkg;

  localparam logic [1:0] XMIT_CONFIG = 2'd0;
  localparam logic [1:0] XMIT_IDLE   = 2'd1;
  localparam logic [1:0] XMIT_DATA   = 2'd2;

  localparam int unsigned ACK_BIT = 14;

  typedef enum logic [2:0] {
    AN_ENABLE,
    AN_RESTART,
    ABILITY_DETECT,
    ACKNOWLEDGE_DETECT,
    COMPLETE_ACKNOWLEDGE,
    IDLE_DETECT,
    LINK_OK,
    AN_DISABLE_LINK_OK
  } an_state_t;

  function automatic logic [15:0] mask_ack(input logic [15:0] word);
    logic [15:0] w;
    w          = word;
    w[ACK_BIT] = 1'b0;
    return w;
  endfunction

  function automatic logic [15:0] set_ack(input logic [15:0] word);
    logic [15:0] w;
    w          = word;
    w[ACK_BIT] = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/an_arbiter_match_detect.sv
// Ability / acknowledge / idle run counters and the consistency latch.
module an_match_detect
  import an_arbiter_pkg::*;
#(
  parameter int unsigned MATCH_COUNT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        latch_consistency,
  input  logic        rx_config_valid,
  input  logic [15:0] rx_config_reg,
  input  logic        rx_idle,
  output logic        ability_match,
  output logic        acknowledge_match,
  output logic        consistency_match,
  output logic        idle_match,
  output logic [15:0] rx_word
);

  localparam int unsigned CW = $clog2(MATCH_COUNT + 1);
  localparam logic [CW-1:0] MATCH_MAX = CW'(MATCH_COUNT);
  localparam logic [CW-1:0] ONE = CW'(1);

  logic [CW-1:0] abl_cnt;
  logic [CW-1:0] ack_cnt;
  logic [CW-1:0] idle_cnt;
  logic [15:0]   last_word;
  logic [15:0]   cons_word;
  logic [15:0]   rx_masked;
  logic [15:0]   last_masked;
  logic          same_word;

  assign rx_masked   = mask_ack(rx_config_reg);
  assign last_masked = mask_ack(last_word);
  assign same_word   = (rx_masked == last_masked);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      abl_cnt   <= '0;
      ack_cnt   <= '0;
      idle_cnt  <= '0;
      last_word <= '0;
      cons_word <= '0;
    end else if (clear) begin
      abl_cnt   <= '0;
      ack_cnt   <= '0;
      idle_cnt  <= '0;
      last_word <= '0;
      cons_word <= '0;
    end else begin
      if (latch_consistency)
        cons_word <= last_masked;
      if (rx_config_valid) begin
        last_word <= rx_config_reg;
        idle_cnt  <= '0;
        if (!same_word)
          abl_cnt <= ONE;
        else if (abl_cnt != MATCH_MAX)
          abl_cnt <= abl_cnt + ONE;
        if (!rx_config_reg[ACK_BIT])
          ack_cnt <= '0;
        else if (!same_word)
          ack_cnt <= ONE;
        else if (ack_cnt != MATCH_MAX)
          ack_cnt <= ack_cnt + ONE;
      end else if (rx_idle) begin
        // An idle breaks any /C/ run, so LINK_OK is not kicked by stale config matches.
        abl_cnt <= '0;
        ack_cnt <= '0;
        if (idle_cnt != MATCH_MAX)
          idle_cnt <= idle_cnt + ONE;
      end
    end
  end

  assign ability_match     = (abl_cnt == MATCH_MAX);
  assign acknowledge_match = (ack_cnt == MATCH_MAX);
  assign idle_match        = (idle_cnt == MATCH_MAX);
  assign consistency_match = (cons_word == last_masked);
  assign rx_word           = last_word;

endmodule

// File: rtl/an_arbiter.sv
// Clause 37 auto-negotiation arbiter: state machine, link timer, output registers.
module an_arbiter
  import an_arbiter_pkg::*;
#(
  parameter int unsigned LINK_TIMER_CYCLES = 1250000,
  parameter int unsigned MATCH_COUNT       = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        link_ok,
  input  logic        mr_an_enable,
  input  logic        mr_restart_an,
  input  logic [15:0] mr_adv_ability,
  input  logic        rx_config_valid,
  input  logic [15:0] rx_Config_Reg,
  input  logic        rx_idle,
  input  logic        rx_invalid,
  output logic [1:0]  xmit,
  output logic [15:0] tx_Config_Reg,
  output logic        mr_an_complete,
  output logic        mr_page_rx,
  output logic [15:0] mr_lp_adv_ability
);

  localparam int unsigned TW = (LINK_TIMER_CYCLES > 1) ? $clog2(LINK_TIMER_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(LINK_TIMER_CYCLES - 1);

  an_state_t   state;
  an_state_t   next_state;
  logic        en_q;
  logic [TW-1:0] timer_cnt;
  logic        link_timer_done;
  logic        global_restart;
  logic        entry;
  logic        timer_clear;

  logic        ability_match;
  logic        acknowledge_match;
  logic        consistency_match;
  logic        idle_match;
  logic [15:0] rx_word;
  logic        rx_zero;

  logic [1:0]  xmit_d;
  logic [15:0] tx_d;
  logic        complete_d;
  logic        page_d;
  logic [15:0] lp_d;

  an_match_detect #(
    .MATCH_COUNT(MATCH_COUNT)
  ) u_match (
    .clk               (clk),
    .reset             (reset),
    .clear             (next_state == AN_ENABLE),
    .latch_consistency (entry && (next_state == ACKNOWLEDGE_DETECT)),
    .rx_config_valid   (rx_config_valid),
    .rx_config_reg     (rx_Config_Reg),
    .rx_idle           (rx_idle),
    .ability_match     (ability_match),
    .acknowledge_match (acknowledge_match),
    .consistency_match (consistency_match),
    .idle_match        (idle_match),
    .rx_word           (rx_word)
  );

  assign rx_zero         = (mask_ack(rx_word) == 16'h0000);
  assign link_timer_done = (timer_cnt == TIMER_LAST);
  assign global_restart  = !link_ok || mr_restart_an || (mr_an_enable != en_q) ||
                           (rx_invalid && (xmit == XMIT_CONFIG));

  always_comb begin
    next_state = state;
    case (state)
      AN_ENABLE:
        next_state = mr_an_enable ? AN_RESTART : AN_DISABLE_LINK_OK;
      AN_RESTART:
        if (link_timer_done) next_state = ABILITY_DETECT;
      ABILITY_DETECT:
        if (ability_match && !rx_zero) next_state = ACKNOWLEDGE_DETECT;
      ACKNOWLEDGE_DETECT:
        if (acknowledge_match && consistency_match)
          next_state = COMPLETE_ACKNOWLEDGE;
        else if (acknowledge_match || (ability_match && rx_zero))
          next_state = AN_ENABLE;
      COMPLETE_ACKNOWLEDGE:
        if (ability_match && rx_zero)
          next_state = AN_ENABLE;
        else if (link_timer_done && ability_match)
          next_state = IDLE_DETECT;
      IDLE_DETECT:
        if (ability_match && rx_zero)
          next_state = AN_ENABLE;
        else if (link_timer_done && idle_match)
          next_state = LINK_OK;
      LINK_OK:
        if (ability_match) next_state = AN_ENABLE;
      AN_DISABLE_LINK_OK:
        next_state = state;
      default:
        next_state = AN_ENABLE;
    endcase
    if (global_restart)
      next_state = AN_ENABLE;
  end

  assign entry       = (next_state != state);
  assign timer_clear = entry && ((next_state == AN_RESTART) ||
                                 (next_state == COMPLETE_ACKNOWLEDGE) ||
                                 (next_state == IDLE_DETECT));

  // Output values are decoded from next_state so they update on the entry edge.
  always_comb begin
    xmit_d     = xmit;
    tx_d       = tx_Config_Reg;
    complete_d = mr_an_complete;
    page_d     = mr_page_rx;
    lp_d       = mr_lp_adv_ability;
    case (next_state)
      AN_ENABLE: begin
        xmit_d     = XMIT_CONFIG;
        tx_d       = '0;
        complete_d = 1'b0;
        page_d     = 1'b0;
      end
      AN_RESTART: begin
        xmit_d = XMIT_CONFIG;
        tx_d   = '0;
      end
      ABILITY_DETECT: begin
        xmit_d = XMIT_CONFIG;
        tx_d   = mask_ack(mr_adv_ability);
      end
      ACKNOWLEDGE_DETECT: begin
        xmit_d = XMIT_CONFIG;
        tx_d   = set_ack(mr_adv_ability);
      end
      COMPLETE_ACKNOWLEDGE: begin
        xmit_d = XMIT_CONFIG;
        tx_d   = set_ack(mr_adv_ability);
        if (entry) begin
          page_d = 1'b1;
          lp_d   = rx_word;
        end
      end
      IDLE_DETECT:
        xmit_d = XMIT_IDLE;
      LINK_OK: begin
        xmit_d     = XMIT_DATA;
        complete_d = 1'b1;
      end
      AN_DISABLE_LINK_OK: begin
        xmit_d = XMIT_DATA;
        tx_d   = '0;
      end
      default: begin
        xmit_d = XMIT_CONFIG;
        tx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= AN_ENABLE;
      en_q              <= 1'b0;
      timer_cnt         <= '0;
      xmit              <= XMIT_CONFIG;
      tx_Config_Reg     <= '0;
      mr_an_complete    <= 1'b0;
      mr_page_rx        <= 1'b0;
      mr_lp_adv_ability <= '0;
    end else begin
      state             <= next_state;
      en_q              <= mr_an_enable;
      xmit              <= xmit_d;
      tx_Config_Reg     <= tx_d;
      mr_an_complete    <= complete_d;
      mr_page_rx        <= page_d;
      mr_lp_adv_ability <= lp_d;
      if (timer_clear)
        timer_cnt <= '0;
      else if (!link_timer_done)
        timer_cnt <= timer_cnt + 1'b1;
    end
  end

endmodule
